// File: rtl/modulo_down_counter_if.sv
// -----------------------------------------------------------------------------
// modulo_down_counter_if
// Groups the signals between the button-stepped down counter and its
// surroundings (board I/O, LED drivers, a cascaded next stage).
//
//   btn        raw pushbutton level, asynchronous to clk, may bounce
//   load       synchronous load strobe
//   load_value value to load while load is high
//   count      current count, registered
//   borrow     one-cycle pulse on a 0 -> MODULUS-1 wrap
//   step       one-cycle pulse per accepted press
//
// master: the side that drives the button/load inputs and watches the outputs.
// slave : the counter itself.
// -----------------------------------------------------------------------------
interface modulo_down_counter_if #(
    parameter int WIDTH = 3
);
    logic             btn;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             borrow;
    logic             step;

    modport master (
        output btn,
        output load,
        output load_value,
        input  count,
        input  borrow,
        input  step
    );

    modport slave (
        input  btn,
        input  load,
        input  load_value,
        output count,
        output borrow,
        output step
    );
endinterface

// File: rtl/modulo_down_counter.sv
// -----------------------------------------------------------------------------
// modulo_down_counter
// Button-stepped modulo-MODULUS down counter for the LED board. A raw
// pushbutton is synchronised, debounced and rising-edge detected; each
// accepted press decrements the count, wrapping from 0 to MODULUS-1 with a
// one-cycle borrow pulse so stages can be cascaded.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    modulo_down_counter_if.slave
//            in : btn, load, load_value
//            out: count, borrow, step (all registered)
//
// Parameters:
//   WIDTH            count width in bits
//   MODULUS          count runs MODULUS-1 down to 0 (2 .. 2**WIDTH)
//   DEBOUNCE_CYCLES  consecutive stable synchronised samples needed to
//                    accept a level change (>= 1)
// -----------------------------------------------------------------------------
module modulo_down_counter #(
    parameter int WIDTH           = 3,
    parameter int MODULUS         = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                  clk,
    input logic                  reset,
    modulo_down_counter_if.slave bus
);

    // A one-cycle debounce still needs a 1-bit counter to keep the logic uniform.
    localparam int               DCW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DCW-1:0]   DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] TOP      = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the load check.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

    logic             sync1_q,     sync1_d;
    logic             sync2_q,     sync2_d;
    logic             deb_level_q, deb_level_d;
    logic [DCW-1:0]   deb_cnt_q,   deb_cnt_d;
    logic             step_q,      step_d;
    logic [WIDTH-1:0] count_q,     count_d;
    logic             borrow_q,    borrow_d;

    // -------------------------------------------------------------------------
    // Button path: synchroniser, debounce, rising-edge detect.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so the block
        // stays purely combinational instead of inferring latches.
        sync1_d     = bus.btn;
        sync2_d     = sync1_q;
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;

        // Agreement (or a bounce back) clears the counter; a difference that
        // has persisted for DEBOUNCE_CYCLES samples is accepted.
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DCW'(1);
            end
        end

        // Registered pulse on the same edge the debounced level rises; the
        // release direction produces nothing.
        step_d = deb_level_d & ~deb_level_q;
    end

    // -------------------------------------------------------------------------
    // Count update: load beats step; step at zero wraps and borrows.
    // -------------------------------------------------------------------------
    always_comb begin
        count_d  = count_q;
        borrow_d = 1'b0;

        if (bus.load) begin
            // Out-of-range load values saturate to the top of the sequence;
            // a coincident step is dropped.
            count_d = ({1'b0, bus.load_value} < MOD_EXT) ? bus.load_value : TOP;
        end else if (step_q) begin
            if (count_q == '0) begin
                count_d  = TOP;
                borrow_d = 1'b1;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers. Reset aborts any debounce or pulse in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
            step_q      <= 1'b0;
            count_q     <= TOP;
            borrow_q    <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            step_q      <= step_d;
            count_q     <= count_d;
            borrow_q    <= borrow_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.borrow = borrow_q;
    assign bus.step   = step_q;

endmodule
